// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift path: op encodings, default width, stage payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Payload carried by every stage at the default width; the top re-declares
  // the same shape at its own WIDTH and hands it to the stages as a type parameter.
  typedef struct packed {
    logic [DEF_WIDTH-1:0]   data;
    logic [DEF_SHAMT_W-1:0] shamt;
    shift_op_e              op;
  } stage_pl_t;

endpackage

// File: rtl/shift_stage.sv
// One registered shift stage: conditionally shifts by DIST when its shamt bit is set (SHIFT_ROTATE_EN adds rotate).
// Latency: 1 cycle.
// Backpressure: holds valid and payload while en_i is low; invalid entries still clock data.
module shift_stage
  import shift_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DIST  = 1,
  parameter type pl_t  = stage_pl_t
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic valid_i,
  input  pl_t  pl_i,
  output logic valid_o,
  output pl_t  pl_o
);

  // The shamt bit this stage consumes is the one whose weight equals DIST.
  localparam int SEL = $clog2(DIST);

  logic valid_q;
  pl_t  pl_d;
  pl_t  pl_q;

  // Next payload: same fields, data shifted by DIST when this stage's shamt bit is set.
  always_comb begin
    pl_d = pl_i;
    if (pl_i.shamt[SEL]) begin
      case (pl_i.op)
        OP_SLL:  pl_d.data = pl_i.data << DIST;
        // Arithmetic shift keeps the sign bit, which is the original operand MSB at every stage.
        OP_SRA:  pl_d.data = $signed(pl_i.data) >>> DIST;
`ifdef SHIFT_ROTATE_EN
        OP_ROR:  pl_d.data = (pl_i.data >> DIST) | (pl_i.data << (WIDTH - DIST));
`endif
        default: pl_d.data = pl_i.data >> DIST;
      endcase
    end
  end

  // Stage register: advances only when the pipeline is not stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      pl_q    <= pl_d;
    end
  end

  assign valid_o = valid_q;
  assign pl_o    = pl_q;

endmodule

// File: rtl/pipelined_shift_unit.sv
// Valid/ready barrel shifter, one register stage per shamt bit (16,8,4,2,1); op 11 rotates when SHIFT_ROTATE_EN is defined, else SRL.
// Latency: SHAMT_W register stages (result after edge N+SHAMT_W-1 for accept at edge N); 1 request per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready; bubbles are not collapsed.
module pipelined_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    shift_op_e          op;
  } pl_t;

  // Index 0 is the request port; index k+1 is the output of stage k.
  logic stage_vld [SHAMT_W+1];
  pl_t  stage_pl  [SHAMT_W+1];
  logic stall;
  logic unused_tail;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign stage_vld[0] = in_valid;
  assign stage_pl[0]  = '{data: data_in, shamt: shamt, op: shift_op_e'(op)};

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SHAMT_W - 1 - k)),
      .pl_t  (pl_t)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .en_i    (~stall),
      .valid_i (stage_vld[k]),
      .pl_i    (stage_pl[k]),
      .valid_o (stage_vld[k+1]),
      .pl_o    (stage_pl[k+1])
    );
  end

  assign out_valid = stage_vld[SHAMT_W];
  assign data_out  = stage_pl[SHAMT_W].data;

  // Shift control fields are spent by the time the entry reaches the output.
  assign unused_tail = ^{stage_pl[SHAMT_W].shamt, stage_pl[SHAMT_W].op};

  // Occupancy flag: any stage holding a valid entry.
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= SHAMT_W; k++) begin
      busy = busy | stage_vld[k];
    end
  end

endmodule

// File: doc/pipelined_shift_unit.md
Name: pipelined_shift_unit

Overview:
Registered, valid/ready-handshaked barrel shifter for the ALU shift path.
- Sits between operand select and ALU result mux. Consumes operand, shift amount and opcode; produces shifted result.
- One pipeline stage per shift-amount bit. Stages apply conditional shifts of 16, 8, 4, 2 and 1 in that order.
- Each stage is the registered counterpart of the team's fixed-distance combinational shift stages.

Parameters:
WIDTH, 32, datapath width; power of two, >= 4
SHAMT_W, $clog2(WIDTH), shift-amount width; also the number of pipeline stages

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  request present
in_ready  output  1  request accepted when in_valid && in_ready
data_in  input  WIDTH  operand
shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
op  input  2  00 SLL, 01 SRA, 10 SRL, 11 ROR (see optional feature)
out_valid  output  1  result present
out_ready  input  1  downstream accepts when out_valid && out_ready
data_out  output  WIDTH  shifted result
busy  output  1  any stage holds a valid entry

Behaviour:
- Pipeline: SHAMT_W register stages. Each stage holds {valid, data, remaining shamt bits, op}.
- Stage k (k = 0..SHAMT_W-1) shifts by 2^(SHAMT_W-1-k) if shamt bit [SHAMT_W-1-k] = 1, else passes data through.
- Fill rules per op:
  - SLL: zero fill at LSB.
  - SRA: MSB replicated, i.e. data_in[WIDTH-1] at every stage.
  - SRL: zero fill at MSB.
- Latency: accepted at edge N, result visible at data_out with out_valid = 1 after edge N+SHAMT_W-1 (5 edges for WIDTH=32). Throughput 1 per cycle.
- Stall: stall = out_valid && !out_ready.
  - While stall = 1, all stages hold their contents and in_ready = 0.
  - Bubbles are not collapsed; the whole pipeline freezes.
- in_ready = !stall, combinational from out_ready.
- data_out and out_valid come directly from the last stage register. They stay stable while stalled.
- Invalid stages still clock data; only valid bits gate output.
- Simultaneous accept and drain in one cycle is legal: everything advances.
- busy = OR of all stage valid bits.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - All valid bits 0, all data 0, so out_valid = 0, data_out = 0, busy = 0.
  - in_ready = 1 during and after reset.
  - Reset mid-operation discards all in-flight entries; none emerge afterwards.
- shamt = 0: result equals data_in after full latency.
- Order is strictly FIFO.

Optional Feature:
Macro: SHIFT_ROTATE_EN
- Defined: op 11 = rotate right. Bits shifted out of the LSB re-enter at the MSB in each stage.
- Undefined: op 11 behaves exactly as SRL; no rotate logic is synthesised.

Decomposition:
- Package shift_pkg: op encodings (OP_SLL, OP_SRA, OP_SRL, OP_ROR), default WIDTH constant, stage payload struct typedef {data, shamt, op}.
- Sub-module shift_stage: one registered stage.
  - Parameter DIST.
  - Ports: valid/payload in and out, enable (= !stall).
  - Instantiated SHAMT_W times via generate, with DIST = 2^(SHAMT_W-1-k).

Test Plan:
1. SRA, data_in = 0x80000000, shamt = 4 -> data_out = 0xF8000000, out_valid 5 cycles after accept.
2. SRL, 0x80000000, shamt = 31 -> 0x00000001. SLL, 0x00000001, shamt = 31 -> 0x80000000. SLL, 0x12345678, shamt = 0 -> 0x12345678.
3. Back-to-back stall: five requests on consecutive cycles; out_ready = 0 for 3 cycles once the first result appears.
   - data_out and out_valid held stable, in_ready = 0 throughout.
   - All five results emerge in order with no loss or duplication.
4. Reset mid-operation: reset = 0 with 3 entries in flight -> out_valid = 0 and busy = 0 immediately (no clock edge). After release, nothing emerges; a new request completes normally.
5. op = 11, data_in = 0x0000000F, shamt = 4 -> 0xF0000000 with SHIFT_ROTATE_EN defined; 0x00000000 without it.
6. Random 10k requests with random out_ready, checked against a reference model for every op and shamt 0..31 -> zero mismatches and in-order completion.
